// File: rtl/pipeline_stall_pkg.sv
// Purpose : shared defaults and helpers for the pipeline stall unit.
//   DEFAULT_DATA_W    - default payload width
//   DEFAULT_STAGES    - default number of pipeline stages (= latency)
//   DEFAULT_BUF_DEPTH - default skid buffer entries
//   occ_width()       - bits needed to count 0..depth buffer entries
package pipeline_stall_pkg;

  localparam int DEFAULT_DATA_W    = 32;
  localparam int DEFAULT_STAGES    = 3;
  localparam int DEFAULT_BUF_DEPTH = 2;

  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipeline_stall_unit_buffer_slots.sv
// Purpose : circular FIFO used as the input skid buffer of pipeline_stall_unit.
// Ports   :
//   clk          - clock, rising edge
//   reset        - synchronous active-high reset (empties the buffer)
//   flush        - empties the buffer on the next edge; wins over enq/deq
//   inputs       - data written on enq
//   enq / deq    - push / pop requests (ignored when full / empty)
//   outputs      - head entry, valid whenever buffer_empty is 0
//   buffer_empty - no entries stored
//   buffer_full  - BUF_DEPTH entries stored
module buffer_slots_param
  import pipeline_stall_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int BUF_DEPTH = DEFAULT_BUF_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic [DATA_W-1:0] inputs,
  input  logic              enq,
  input  logic              deq,
  output logic [DATA_W-1:0] outputs,
  output logic              buffer_empty,
  output logic              buffer_full
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = occ_width(BUF_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUF_DEPTH);

  logic [DATA_W-1:0] mem_q [BUF_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_enq, do_deq;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign buffer_empty = (count_q == '0);
  assign buffer_full  = (count_q == FULL_CNT);
  assign outputs      = mem_q[rd_ptr_q];
  assign do_enq       = enq & ~buffer_full;
  assign do_deq       = deq & ~buffer_empty;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_enq) wr_ptr_d = bump(wr_ptr_q);
      if (do_deq) rd_ptr_d = bump(rd_ptr_q);
      count_d = count_q + CNT_W'(do_enq) - CNT_W'(do_deq);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; an entry is only read while count_q says it is live.
  always_ff @(posedge clk) begin
    if (do_enq && !flush && !reset) mem_q[wr_ptr_q] <= inputs;
  end

endmodule

// File: rtl/pipeline_stall_unit.sv
// Purpose : STAGES-deep data pipeline with global stall, input skid buffer and
//           a delayed flush pulse.
// Ports   :
//   clk        - clock, rising edge
//   reset      - synchronous active-high reset, overrides in_flush
//   in_flush   - clears buffer and pipeline on the next edge, drops this cycle's beat
//   inputs     - upstream payload, qualified by in_valid
//   in_valid   - upstream payload valid (must be low while out_stall)
//   in_stall   - downstream back-pressure; stalls only when out_valid is high
//   outputs    - payload of the last stage
//   out_valid  - last stage holds a valid payload
//   out_flush  - in_flush delayed by STAGES cycles, independent of stalls
//   occupancy  - buffer entries (only with PIPELINE_STALL_UNIT_OCC_EN defined)
//   out_stall  - skid buffer full
// Config  : define PIPELINE_STALL_UNIT_OCC_EN to add the occupancy output.
module pipeline_stall_unit
  import pipeline_stall_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int STAGES    = DEFAULT_STAGES,
  parameter int BUF_DEPTH = DEFAULT_BUF_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_flush,
  input  logic [DATA_W-1:0] inputs,
  input  logic              in_valid,
  input  logic              in_stall,
  output logic [DATA_W-1:0] outputs,
  output logic              out_valid,
  output logic              out_flush,
`ifdef PIPELINE_STALL_UNIT_OCC_EN
  output logic [occ_width(BUF_DEPTH)-1:0] occupancy,
`endif
  output logic              out_stall
);

  logic [DATA_W-1:0] data_q [STAGES];
  logic [DATA_W-1:0] data_d [STAGES];
  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] flush_q, flush_d;

  logic [DATA_W-1:0] buf_head, src_data;
  logic              buf_empty, buf_full;
  logic              enq, deq, advance, src_valid;

  buffer_slots_param #(
    .DATA_W    (DATA_W),
    .BUF_DEPTH (BUF_DEPTH)
  ) u_buffer (
    .clk          (clk),
    .reset        (reset),
    .flush        (in_flush),
    .inputs       (inputs),
    .enq          (enq),
    .deq          (deq),
    .outputs      (buf_head),
    .buffer_empty (buf_empty),
    .buffer_full  (buf_full)
  );

  assign out_valid = valid_q[STAGES-1];
  assign outputs   = data_q[STAGES-1];
  assign out_flush = flush_q[STAGES-1];
  assign out_stall = buf_full;

  // The whole pipeline moves as one; only a valid, blocked last stage holds it.
  assign advance   = ~(in_stall & out_valid);

  // Buffered beats are older than the current input, so they go first.
  assign src_valid = ~buf_empty | in_valid;
  assign src_data  = buf_empty ? inputs : buf_head;

  // A beat is buffered only when it cannot bypass straight into stage 0.
  assign enq = in_valid & ~buf_full & ~in_flush & (~buf_empty | ~advance);
  assign deq = ~buf_empty & advance & ~in_flush;

  always_comb begin
    flush_d[0] = in_flush;
    for (int k = 1; k < STAGES; k++) flush_d[k] = flush_q[k-1];
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_flush) begin
      valid_d = '0;
      for (int k = 0; k < STAGES; k++) data_d[k] = '0;
    end else if (advance) begin
      valid_d[0] = src_valid;
      if (src_valid) data_d[0] = src_data;
      for (int k = 1; k < STAGES; k++) begin
        valid_d[k] = valid_q[k-1];
        if (valid_q[k-1]) data_d[k] = data_q[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      flush_q <= '0;
      for (int k = 0; k < STAGES; k++) data_q[k] <= '0;
    end else begin
      valid_q <= valid_d;
      flush_q <= flush_d;
      data_q  <= data_d;
    end
  end

`ifdef PIPELINE_STALL_UNIT_OCC_EN
  localparam int OCC_W = occ_width(BUF_DEPTH);
  logic [OCC_W-1:0] occ_q, occ_d;

  // Tracks the buffer's own enq/deq decisions, which are already gated.
  always_comb begin
    occ_d = occ_q;
    if (in_flush) occ_d = '0;
    else          occ_d = occ_q + OCC_W'(enq) - OCC_W'(deq);
  end

  always_ff @(posedge clk) begin
    if (reset) occ_q <= '0;
    else       occ_q <= occ_d;
  end

  assign occupancy = occ_q;
`endif

endmodule

// File: tb/tb_pipeline_stall_unit.sv
module tb_pipeline_stall_unit;
  import pipeline_stall_pkg::*;

  localparam int DW = 32;
  localparam int ST = 3;
  localparam int BD = 2;

  logic          clk = 1'b0;
  logic          reset, in_flush, in_valid, in_stall;
  logic [DW-1:0] inputs, outputs;
  logic          out_valid, out_flush, out_stall;
`ifdef PIPELINE_STALL_UNIT_OCC_EN
  logic [occ_width(BD)-1:0] occupancy;
`endif

  always #5 clk = ~clk;

  pipeline_stall_unit #(.DATA_W(DW), .STAGES(ST), .BUF_DEPTH(BD)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_flush  (in_flush),
    .inputs    (inputs),
    .in_valid  (in_valid),
    .in_stall  (in_stall),
    .outputs   (outputs),
    .out_valid (out_valid),
    .out_flush (out_flush),
`ifdef PIPELINE_STALL_UNIT_OCC_EN
    .occupancy (occupancy),
`endif
    .out_stall (out_stall)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: occupancy count, which stage slots hold a beat, the
  // flush delay line, and the ordered list of accepted beats still owed.
  int            m_cnt;
  bit            m_v [ST];
  bit            m_f [ST];
  bit            m_clr;
  logic [DW-1:0] exp_q [$];
  bit            mon_en = 1'b0;

  task automatic model_step();
    bit adv, empty, full, acc;
    if (reset) begin
      m_cnt = 0;
      for (int k = 0; k < ST; k++) begin m_v[k] = 1'b0; m_f[k] = 1'b0; end
      exp_q.delete();
      m_clr = 1'b1;
      return;
    end
    adv   = !(in_stall && m_v[ST-1]);
    empty = (m_cnt == 0);
    full  = (m_cnt == BD);
    acc   = in_valid && !full;
    for (int k = ST-1; k > 0; k--) m_f[k] = m_f[k-1];
    m_f[0] = in_flush;
    m_clr  = in_flush;
    if (in_flush) begin
      m_cnt = 0;
      for (int k = 0; k < ST; k++) m_v[k] = 1'b0;
      exp_q.delete();
    end else begin
      if (acc) exp_q.push_back(inputs);
      if (adv) begin
        for (int k = ST-1; k > 0; k--) m_v[k] = m_v[k-1];
        m_v[0] = !empty || in_valid;
        if (!empty) m_cnt--;
        if (acc && !empty) m_cnt++;
      end else if (acc) begin
        m_cnt++;
      end
    end
  endtask

  task automatic drive(input bit iv, input logic [DW-1:0] d, input bit st,
                       input bit fl, input bit rs);
    in_valid = iv;
    inputs   = d;
    in_stall = st;
    in_flush = fl;
    reset    = rs;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: cycle-level checks against the model plus in-order scoreboard.
  bit            prev_hold = 1'b0;
  logic [DW-1:0] prev_data;

  always @(negedge clk) begin
    if (mon_en) begin
      check("out_valid", out_valid, m_v[ST-1]);
      check("out_stall", out_stall, m_cnt == BD);
      check("out_flush", out_flush, m_f[ST-1]);
`ifdef PIPELINE_STALL_UNIT_OCC_EN
      check("occupancy", occupancy, m_cnt);
`endif
      if (m_clr) check("cleared_outputs", outputs, '0);
      if (prev_hold && !m_clr) check("hold_data", outputs, prev_data);
      if (out_valid && !in_stall) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got 0x%0h expected no beat at %0t", outputs, $time);
        end else begin
          check("sb_data", outputs, exp_q.pop_front());
        end
      end
      prev_hold = out_valid && in_stall;
      prev_data = outputs;
    end
  end

  initial begin
    in_valid = 1'b0; inputs = '0; in_stall = 1'b0; in_flush = 1'b0; reset = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b1, 1'b1);   // reset wins over a concurrent flush
    mon_en = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    idle(2);

    // Streaming 1,2,3 with no stall.
    drive(1'b1, 32'h1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h2, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h3, 1'b0, 1'b0, 1'b0);
    idle(5);

    // Stall with skid buffer filling, then release.
    drive(1'b1, 32'h9, 1'b0, 1'b0, 1'b0);
    idle(2);
    drive(1'b1, 32'hA, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 32'hB, 1'b1, 1'b0, 1'b0);
    drive(1'b0, '0,    1'b1, 1'b0, 1'b0);
    drive(1'b0, '0,    1'b1, 1'b0, 1'b0);
    drive(1'b0, '0,    1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'hC, 1'b0, 1'b0, 1'b0);
    idle(8);

    // Flush with three beats in flight and one buffered.
    drive(1'b1, 32'h20, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h21, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h22, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h23, 1'b1, 1'b0, 1'b0);
    drive(1'b0, '0,     1'b1, 1'b1, 1'b0);
    idle(5);

    // Flush together with a valid beat: 0x55 must never be delivered.
    drive(1'b1, 32'h55, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 32'h56, 1'b0, 1'b1, 1'b0);   // back-to-back flush pulses
    idle(6);

    // Reset mid-stream with three beats in flight.
    drive(1'b1, 32'h31, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h32, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h33, 1'b0, 1'b0, 1'b0);
    drive(1'b0, '0,     1'b0, 1'b0, 1'b1);
    idle(5);

    // Simultaneous enqueue and dequeue at occupancy 1.
    drive(1'b1, 32'h41, 1'b0, 1'b0, 1'b0);
    idle(2);
    drive(1'b1, 32'h42, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 32'h43, 1'b0, 1'b0, 1'b0);
    idle(6);

    // Randomized traffic, including protocol-violating beats while full.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 9) < 6, $urandom | 32'h100,
            $urandom_range(0, 9) < 3, $urandom_range(0, 99) < 3,
            $urandom_range(0, 199) < 1);
    end

    idle(ST + BD + 4);
    check("drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
